// File: rtl/sccb_target_if.sv
// sccb_target_if
//   Groups the SCCB target's clock input and its host-side signals.
//   sda is an open-drain wire, so it is carried as a plain inout net on the
//   target module itself rather than inside this interface.
//   Signals:
//     scl       SCCB clock from the bus master (never stretched)
//     wr_valid  one-cycle pulse per data byte written to the register file
//     wr_addr   register address of the last write
//     wr_data   data of the last write
//     busy      high from START to STOP
//     dbg_addr  register-file peek address
//     dbg_data  regfile[dbg_addr], registered, one cycle of latency
interface sccb_target_if;
    logic       scl;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;

    modport slave (
        input  scl, dbg_addr,
        output wr_valid, wr_addr, wr_data, busy, dbg_data
    );

    modport master (
        output scl, dbg_addr,
        input  wr_valid, wr_addr, wr_data, busy, dbg_data
    );
endinterface

// File: rtl/sccb_target.sv
// sccb_target
//   SCCB/I2C target backed by a 256x8 register file that stands in for the
//   OV7670 register space. It accepts 3-phase writes (ID, sub-address, data,
//   with auto-increment) and 2-phase writes (ID, sub-address). It serves reads
//   from the current sub-address pointer, which persists across transactions.
//   Ports:
//     clk  system clock, at least 20x SCL
//     rst  asynchronous active-high reset
//     bus  sccb_target_if.slave (scl, write report, busy, debug peek)
//     sda  open-drain data line, driven 0 or Z only
module sccb_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21
) (
    input  logic           clk,
    input  logic           rst,
    sccb_target_if.slave   bus,
    inout  wire            sda
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ID_W,
        S_SUB,
        S_ACK_SUB,
        S_DATA,
        S_ACK_DATA,
        S_ACK_ID_R,
        S_TX,
        S_MACK,
        S_IGNORE
    } state_t;

    state_t      state_q;
    logic [2:0]  scl_sync_q;
    logic [2:0]  sda_sync_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_sh_q;
    logic [7:0]  tx_sh_q;
    logic        tx_first_q;
    logic [7:0]  ptr_q;
    logic        sda_oe_q;
    logic        wr_valid_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        busy_q;
    logic [7:0]  dbg_data_q;
    logic [7:0]  regs_q [256];

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  rx_byte_d;
    logic [7:0]  ptr_inc_d;

    // Index [1] is the synchronized value, [2] its previous-cycle copy used
    // for edge detection.
    assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
    assign start_det =  scl_sync_q[1] &  scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
    assign stop_det  =  scl_sync_q[1] &  scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];
    assign rx_byte_d = {rx_sh_q[6:0], sda_sync_q[1]};
    assign ptr_inc_d = ptr_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            tx_first_q <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            dbg_data_q <= '0;
            for (int unsigned i = 0; i < 256; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], bus.scl};
            sda_sync_q <= {sda_sync_q[1:0], sda};
            wr_valid_q <= 1'b0;
            // Reads the pre-write value on a same-cycle write collision.
            dbg_data_q <= regs_q[bus.dbg_addr];

            if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= '0;
                busy_q    <= 1'b1;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_SUB, S_DATA: begin
                        if (scl_rise) begin
                            rx_sh_q   <= rx_byte_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (state_q)
                                    S_ADDR: begin
                                        if (rx_byte_d[7:1] != DEV_ADDR)
                                            state_q <= S_IGNORE;
                                        else if (rx_byte_d[0])
                                            state_q <= S_ACK_ID_R;
                                        else
                                            state_q <= S_ACK_ID_W;
                                    end
                                    S_SUB: begin
                                        ptr_q   <= rx_byte_d;
                                        state_q <= S_ACK_SUB;
                                    end
                                    default: begin
                                        regs_q[ptr_q] <= rx_byte_d;
                                        wr_valid_q    <= 1'b1;
                                        wr_addr_q     <= ptr_q;
                                        wr_data_q     <= rx_byte_d;
                                        ptr_q         <= ptr_inc_d;
                                        state_q       <= S_ACK_DATA;
                                    end
                                endcase
                            end
                        end
                    end

                    // First falling edge pulls sda low, the second releases it.
                    S_ACK_ID_W, S_ACK_SUB, S_ACK_DATA: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= (state_q == S_ACK_ID_W) ? S_SUB : S_DATA;
                            end
                        end
                    end

                    // The falling edge that ends the ACK also presents bit 7.
                    S_ACK_ID_R: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                tx_sh_q    <= regs_q[ptr_q];
                                sda_oe_q   <= ~regs_q[ptr_q][7];
                                tx_first_q <= 1'b0;
                                bit_cnt_q  <= '0;
                                state_q    <= S_TX;
                            end
                        end
                    end

                    // tx_first_q marks a reloaded byte whose bit 7 has not yet
                    // been presented (entered from MACK on a rising edge).
                    S_TX: begin
                        if (scl_fall) begin
                            if (tx_first_q) begin
                                sda_oe_q   <= ~tx_sh_q[7];
                                tx_first_q <= 1'b0;
                                bit_cnt_q  <= '0;
                            end else if (bit_cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= S_MACK;
                            end else begin
                                tx_sh_q   <= {tx_sh_q[6:0], 1'b0};
                                sda_oe_q  <= ~tx_sh_q[6];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end

                    S_MACK: begin
                        if (scl_rise) begin
                            if (!sda_sync_q[1]) begin
                                ptr_q      <= ptr_inc_d;
                                tx_sh_q    <= regs_q[ptr_inc_d];
                                tx_first_q <= 1'b1;
                                state_q    <= S_TX;
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign sda          = sda_oe_q ? 1'b0 : 1'bz;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target
//   Directed bus-master sequences against sccb_target. Expected register
//   writes are queued as the master sends data bytes and compared when the
//   target pulses wr_valid.
module tb_sccb_target;

    localparam int Q = 10;   // quarter SCL period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_low = 1'b0;      // master pulls sda low when set
    wire  sda;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    sccb_target_if bus ();

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    sccb_target #(.DEV_ADDR(7'h21)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .sda (sda)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every wr_valid pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL wr_unexpected observed=%h%h expected=none", bus.wr_addr, bus.wr_data);
            end
            if (exp_q.size() != 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("wr_addr_data", {bus.wr_addr, bus.wr_data}, e);
            end
        end
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        m_low = 1'b0; bus.scl = 1'b1; w(Q);
        m_low = 1'b1; w(Q);
        bus.scl = 1'b0; w(Q);
    endtask

    task automatic m_stop();
        m_low = 1'b1; w(Q);
        bus.scl = 1'b1; w(Q);
        m_low = 1'b0; w(Q);
    endtask

    task automatic m_bit(input logic b);
        m_low = ~b; w(Q);
        bus.scl = 1'b1; w(2 * Q);
        bus.scl = 1'b0; w(Q);
    endtask

    task automatic m_rbit(output logic b);
        m_low = 1'b0; w(Q);
        bus.scl = 1'b1; w(Q);
        b = sda;
        w(Q);
        bus.scl = 1'b0; w(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit(d[i]);
        m_rbit(ack);
    endtask

    task automatic m_rbyte(output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            m_rbit(b);
            d = {d[6:0], b};
        end
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.dbg_addr = a;
        w(2);
        chk(tag, {8'h00, bus.dbg_data}, {8'h00, exp});
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;

        bus.scl      = 1'b1;
        bus.dbg_addr = 8'h00;
        w(5);
        chk("rst_busy",   {15'd0, bus.busy},     16'd0);
        chk("rst_wr_vld", {15'd0, bus.wr_valid}, 16'd0);
        chk("rst_wr_ad",  {bus.wr_addr, bus.wr_data}, 16'h0000);
        chk("rst_dbg",    {8'h00, bus.dbg_data}, 16'h0000);
        chk("rst_sda",    {15'd0, sda},          16'd1);
        rst = 1'b0;
        w(5);

        // 3-phase write 0x12 = 0x80
        m_start();
        chk("w3_busy_hi", {15'd0, bus.busy}, 16'd1);
        m_wbyte(8'h42, ack); chk("w3_ack_id",  {15'd0, ack}, 16'd0);
        m_wbyte(8'h12, ack); chk("w3_ack_sub", {15'd0, ack}, 16'd0);
        exp_q.push_back(16'h1280);
        m_wbyte(8'h80, ack); chk("w3_ack_dat", {15'd0, ack}, 16'd0);
        m_stop();
        w(5);
        chk("w3_busy_lo", {15'd0, bus.busy}, 16'd0);
        chk("w3_hold",    {bus.wr_addr, bus.wr_data}, 16'h1280);
        peek("w3_peek", 8'h12, 8'h80);

        // Wrong device ID: NACK, no write
        m_start();
        m_wbyte(8'h44, ack); chk("wid_nack", {15'd0, ack}, 16'd1);
        m_wbyte(8'h55, ack);
        m_wbyte(8'h01, ack);
        m_stop();
        peek("wid_peek", 8'h55, 8'h00);

        // Read back via 2-phase pointer set
        m_start();
        m_wbyte(8'h42, ack);
        m_wbyte(8'h55, ack);
        exp_q.push_back(16'h553C);
        m_wbyte(8'h3C, ack);
        m_stop();
        m_start();
        m_wbyte(8'h42, ack); chk("rd_ack_id",  {15'd0, ack}, 16'd0);
        m_wbyte(8'h55, ack); chk("rd_ack_sub", {15'd0, ack}, 16'd0);
        m_stop();
        m_start();
        m_wbyte(8'h43, ack); chk("rd_ack_rid", {15'd0, ack}, 16'd0);
        m_rbyte(rd);         chk("rd_data", {8'h00, rd}, 16'h003C);
        m_bit(1'b1);
        w(Q);
        chk("rd_sda_rel", {15'd0, sda}, 16'd1);
        m_stop();

        // Burst write with pointer wrap
        m_start();
        m_wbyte(8'h42, ack);
        m_wbyte(8'hFF, ack);
        exp_q.push_back(16'hFFA1);
        m_wbyte(8'hA1, ack);
        exp_q.push_back(16'h00A2);
        m_wbyte(8'hA2, ack); chk("bst_ack", {15'd0, ack}, 16'd0);
        m_stop();
        peek("bst_ff", 8'hFF, 8'hA1);
        peek("bst_00", 8'h00, 8'hA2);

        // Burst read with master ACK across the wrap
        m_start();
        m_wbyte(8'h42, ack);
        m_wbyte(8'hFF, ack);
        m_stop();
        m_start();
        m_wbyte(8'h43, ack);
        m_rbyte(rd); chk("brd_0", {8'h00, rd}, 16'h00A1);
        m_bit(1'b0);
        m_rbyte(rd); chk("brd_1", {8'h00, rd}, 16'h00A2);
        m_bit(1'b1);
        m_stop();

        // Abort after 4 data bits, then a normal transaction
        m_start();
        m_wbyte(8'h42, ack);
        m_wbyte(8'h10, ack);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b1);
        m_stop();
        w(5);
        chk("abt_busy", {15'd0, bus.busy}, 16'd0);
        peek("abt_peek", 8'h10, 8'h00);
        m_start();
        m_wbyte(8'h42, ack); chk("abt_ack_id", {15'd0, ack}, 16'd0);
        m_wbyte(8'h10, ack);
        exp_q.push_back(16'h1077);
        m_wbyte(8'h77, ack); chk("abt_ack_dat", {15'd0, ack}, 16'd0);
        m_stop();
        peek("abt_peek2", 8'h10, 8'h77);

        // Reset while the target drives the ACK
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(1'(8'h42 >> i));
        m_low = 1'b0;
        w(Q);
        chk("rma_drive", {15'd0, sda}, 16'd0);
        rst = 1'b1;
        #1;
        chk("rma_sda_z", {15'd0, sda}, 16'd1);
        w(3);
        chk("rma_busy", {15'd0, bus.busy}, 16'd0);
        bus.scl = 1'b1;
        w(3);
        rst = 1'b0;
        w(5);
        peek("rma_peek", 8'h12, 8'h00);

        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
